// File: rtl/wb_ram_b3.sv
// Wishbone B3 single-port RAM slave with registered feedback.
// Supports classic cycles (2 cycles/access) and incrementing bursts (linear,
// wrap-4/8/16) at one beat per cycle.
// Ports: clk_i/rst_ni (async active-low), adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/
//        cti_i/bte_i from master; dat_o/ack_o/err_o/rty_o back to master.
module wb_ram_b3 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_WIDTH-1:0]     adr_i,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic [DATA_WIDTH/8-1:0]   sel_i,
  input  logic                      we_i,
  input  logic [2:0]                cti_i,
  input  logic [1:0]                bte_i,
  output logic [DATA_WIDTH-1:0]     dat_o,
  output logic                      ack_o,
  output logic                      err_o,
  output logic                      rty_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int OFS       = $clog2(SEL_WIDTH);
  localparam int IDX       = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, CLASSIC, BURST, ERR} state_t;

  state_t                state, state_nxt;
  logic                  ack_r, ack_nxt;
  logic [IDX-1:0]        exp_idx, exp_nxt;
  logic [IDX-1:0]        idx, nxt_idx, inc_idx, wrap_mask, rd_idx;
  logic                  rd_en, req, misaligned, wr_en;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Upper address bits are decoded upstream; fold them here so they count as consumed.
  logic unused_adr;
  assign unused_adr = ^adr_i;

  assign idx        = adr_i[IDX+OFS-1:OFS];
  assign misaligned = |(adr_i & ADDR_WIDTH'(SEL_WIDTH - 1));
  assign req        = cyc_i & stb_i;

  // In a burst the master must present exactly the word we prefetched.
  assign ack_o = ack_r & req & ~misaligned & (state != IDLE) &
                 ((state != BURST) | (idx == exp_idx));
  assign err_o = (state == ERR) & req;
  assign rty_o = 1'b0;
  assign wr_en = ack_o & we_i;

  // Next burst address: linear increments through the whole array, wrap
  // modes only advance the low log2(N) bits.
  always_comb begin
    wrap_mask = '0;
    case (bte_i)
      2'b01:   wrap_mask = IDX'(3);
      2'b10:   wrap_mask = IDX'(7);
      2'b11:   wrap_mask = IDX'(15);
      default: wrap_mask = '0;
    endcase
    inc_idx = exp_idx + 1'b1;
    if (bte_i == 2'b00) nxt_idx = inc_idx;
    else                nxt_idx = (exp_idx & ~wrap_mask) | (inc_idx & wrap_mask);
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = ack_r;
    exp_nxt   = exp_idx;
    rd_en     = 1'b0;
    rd_idx    = idx;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            state_nxt = ERR;
          end else begin
            rd_en     = 1'b1;
            rd_idx    = idx;
            ack_nxt   = 1'b1;
            exp_nxt   = idx;
            state_nxt = (cti_i == 3'b010) ? BURST : CLASSIC;
          end
        end
      end
      CLASSIC: begin
        ack_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      BURST: begin
        if (!cyc_i) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (stb_i) begin
          if (ack_o && cti_i == 3'b010) begin
            // Prefetch the next beat so data is ready with no wait state.
            exp_nxt = nxt_idx;
            rd_en   = 1'b1;
            rd_idx  = nxt_idx;
          end else begin
            // Last beat, or address mismatch: drop back and let IDLE re-accept.
            ack_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
        // stb_i low with cyc_i high is a master wait state: hold everything.
      end
      default: begin
        ack_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ack_r   <= 1'b0;
      exp_idx <= '0;
      dat_o   <= '0;
    end else begin
      state   <= state_nxt;
      ack_r   <= ack_nxt;
      exp_idx <= exp_nxt;
      // Read of the pre-write contents: a same-edge write is not forwarded.
      if (rd_en) dat_o <= mem[rd_idx];
    end
  end

  // Memory array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (sel_i[b]) mem[idx][b*8 +: 8] <= dat_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_b3.sv
module tb_wb_ram_b3;

  localparam int MW = 1024;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic        we_i = 1'b0;
  logic [2:0]  cti_i = '0;
  logic [1:0]  bte_i = '0;
  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o;

  wb_ram_b3 dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr_i), .dat_i(dat_i),
    .cyc_i(cyc_i), .stb_i(stb_i), .sel_i(sel_i), .we_i(we_i),
    .cti_i(cti_i), .bte_i(bte_i), .dat_o(dat_o), .ack_o(ack_o),
    .err_o(err_o), .rty_o(rty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        is_err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model[MW];
  bit          known[MW];
  int          n_vec = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference memory: byte-lane merge, word becomes fully known on a full-word write.
  function automatic void mwrite(input int i, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) model[i][b*8 +: 8] = d[b*8 +: 8];
    if (s == 4'hF) known[i] = 1'b1;
  endfunction

  // Burst address sequence from the address rules: linear mod depth, or wrap in N-word block.
  function automatic int nxt(input int i, input logic [1:0] b);
    int n;
    if (b == 2'b00) return (i + 1) % MW;
    n = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : 16;
    return (i / n) * n + ((i % n) + 1) % n;
  endfunction

  // Every acked beat returns the word's contents from before this beat's write.
  task automatic push_beat(input int i, input logic w, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.is_err = 1'b0;
    e.chk    = known[i];
    e.dat    = model[i];
    sb.push_back(e);
    if (w) mwrite(i, d, s);
  endtask

  task automatic wait_ack(output int n);
    n = 99;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      if (ack_o) begin
        n = c;
        break;
      end
    end
  endtask

  // Monitor: every response the DUT presents is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && (ack_o || err_o)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_resp: ack=%b err=%b, expected no response at %0t", ack_o, err_o, $time);
      end else begin
        mon_e = sb.pop_front();
        check("resp_err", 32'(err_o), 32'(mon_e.is_err));
        check("resp_ack", 32'(ack_o), 32'(!mon_e.is_err));
        if (!mon_e.is_err && mon_e.chk) check("resp_data", dat_o, mon_e.dat);
      end
    end
  end

  task automatic classic(input int i, input logic w, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd);
    int n;
    adr_i = 32'(i) << 2; dat_i = d; sel_i = s; we_i = w;
    cti_i = 3'b000; bte_i = 2'b00; cyc_i = 1'b1; stb_i = 1'b1;
    push_beat(i, w, d, s);
    wait_ack(n);
    rd = dat_o;
    check("classic_lat", 32'(n), 32'd2);
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic burst(input int start, input int nbeats, input logic [1:0] b, input logic w,
                       input logic [3:0] s, input int gap_at, input int bad_at);
    int idx, n;
    logic [31:0] d;
    idx = start;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; sel_i = s; bte_i = b;
    for (int k = 0; k < nbeats; k++) begin
      d = $urandom;
      if (k == bad_at && k > 0) begin
        adr_i = 32'((idx + 5) % MW) << 2; dat_i = d; cti_i = 3'b010;
        @(negedge clk_i);
        check("mismatch_ack", 32'(ack_o), 32'd0);
        @(posedge clk_i); #1;
        return;
      end
      if (k == gap_at && k > 0) begin
        stb_i = 1'b0;
        repeat (2) begin
          @(negedge clk_i);
          check("gap_ack", 32'(ack_o), 32'd0);
          @(posedge clk_i); #1;
        end
        stb_i = 1'b1;
      end
      adr_i = 32'(idx) << 2; dat_i = d;
      cti_i = (k == nbeats - 1) ? 3'b111 : 3'b010;
      push_beat(idx, w, d, s);
      wait_ack(n);
      check("beat_lat", 32'(n), (k == 0) ? 32'd2 : 32'd1);
      @(posedge clk_i); #1;
      idx = nxt(idx, b);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n, len, gap;
    exp_t e;

    #1;
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rty", 32'(rty_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Fill the whole array with a linear write burst so every word is known.
    burst(0, MW, 2'b00, 1'b1, 4'hF, -1, -1);

    classic(4, 1'b1, 32'hA5A5_1234, 4'hF, rd);
    classic(4, 1'b0, 32'h0, 4'hF, rd);
    check("classic_rd", rd, 32'hA5A5_1234);

    classic(8, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
    classic(8, 1'b1, 32'h0000_0000, 4'b0010, rd);
    classic(8, 1'b0, 32'h0, 4'hF, rd);
    check("byte_lane_rd", rd, 32'hFFFF_00FF);

    burst(14, 4, 2'b01, 1'b0, 4'hF, -1, -1);
    burst(21, 10, 2'b10, 1'b1, 4'hF, -1, -1);
    burst(40, 18, 2'b11, 1'b0, 4'hF, -1, -1);

    burst(100, 6, 2'b00, 1'b1, 4'hF, 3, -1);

    burst(200, 6, 2'b00, 1'b1, 4'hF, -1, 3);
    classic(203, 1'b0, 32'h0, 4'hF, rd);
    classic(208, 1'b0, 32'h0, 4'hF, rd);

    // Misaligned write onto word 4: one-cycle error, no ack, no write.
    adr_i = 32'h13; dat_i = 32'hDEAD_BEEF; sel_i = 4'hF; we_i = 1'b1;
    cti_i = 3'b000; cyc_i = 1'b1; stb_i = 1'b1;
    e.is_err = 1'b1; e.chk = 1'b0; e.dat = '0;
    sb.push_back(e);
    @(negedge clk_i);
    check("mis_err_c1", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("mis_err_c2", 32'(err_o), 32'd1);
    check("mis_ack", 32'(ack_o), 32'd0);
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    check("mis_err_c3", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;
    classic(4, 1'b0, 32'h0, 4'hF, rd);
    check("mis_unchanged", rd, 32'hA5A5_1234);

    // Reset in the middle of a read burst.
    adr_i = 32'(300) << 2; we_i = 1'b0; cti_i = 3'b010; bte_i = 2'b00; sel_i = 4'hF;
    cyc_i = 1'b1; stb_i = 1'b1;
    push_beat(300, 1'b0, 32'h0, 4'hF);
    wait_ack(n);
    check("rst_b0_lat", 32'(n), 32'd2);
    @(posedge clk_i); #1;
    adr_i = 32'(301) << 2;
    push_beat(301, 1'b0, 32'h0, 4'hF);
    #2;
    check("pre_rst_ack", 32'(ack_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("midrst_ack", 32'(ack_o), 32'd0);
    check("midrst_dat", dat_o, 32'd0);
    void'(sb.pop_back());
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_ack", 32'(ack_o), 32'd0);
    @(posedge clk_i); #1;
    classic(301, 1'b0, 32'h0, 4'hF, rd);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 2))
        0: classic($urandom_range(0, MW - 1), 1'b0, 32'h0, 4'hF, rd);
        1: classic($urandom_range(0, MW - 1), 1'b1, $urandom, 4'($urandom), rd);
        default: begin
          len = $urandom_range(1, 12);
          gap = ($urandom_range(0, 3) == 0 && len > 1) ? $urandom_range(1, len - 1) : -1;
          burst($urandom_range(0, MW - 1), len, 2'($urandom), 1'($urandom),
                4'($urandom), gap, -1);
        end
      endcase
    end

    // Read back everything through one long linear burst.
    burst(0, MW, 2'b00, 1'b0, 4'hF, -1, -1);
    repeat (2) @(posedge clk_i);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
